// File: rtl/rpm_mult_scheduler.sv
// rpm_mult_scheduler: two requesters share one iterative shift-add multiplier.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid[1:0]      per-requester request valid
//   req_ready[1:0]      per-requester grant/accept strobe (combinational, IDLE only)
//   req_a0/req_b0       requester 0 multiplicand / multiplier
//   req_a1/req_b1       requester 1 multiplicand / multiplier
//   res_valid           result valid (DONE state)
//   res_ready           result consumer ready
//   res_id              requester that owns the result
//   res_product         unsigned 2*WIDTH-bit product, retained after consumption
//   busy                high whenever the FSM is not idle
module rpm_mult_scheduler #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [WIDTH-1:0]     req_a0,
    input  logic [WIDTH-1:0]     req_b0,
    input  logic [WIDTH-1:0]     req_a1,
    input  logic [WIDTH-1:0]     req_b1,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 res_id,
    output logic [2*WIDTH-1:0]   res_product,
    output logic                 busy
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 id_q, id_d;
    logic                 last_q, last_d;
    logic [1:0]           grant;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        id_d     = id_q;
        last_d   = last_q;
        grant    = 2'b00;

        unique case (state_q)
            StIdle: begin
                unique case (req_valid)
                    2'b01:   grant = 2'b01;
                    2'b10:   grant = 2'b10;
                    // Contention: favour whoever was not granted last.
                    2'b11:   grant = last_q ? 2'b01 : 2'b10;
                    default: grant = 2'b00;
                endcase
                if (grant != 2'b00) begin
                    mcand_d  = grant[1] ? {{WIDTH{1'b0}}, req_a1} : {{WIDTH{1'b0}}, req_a0};
                    mplier_d = grant[1] ? req_b1 : req_b0;
                    acc_d    = '0;
                    id_d     = grant[1];
                    last_d   = grant[1];
                    cnt_d    = CntW'(WIDTH);
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (cnt_q != '0) begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q - 1'b1;
                end else begin
                    // Count exhausted: all WIDTH steps are in acc_q.
                    state_d = StDone;
                end
            end
            StDone: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            id_q     <= 1'b0;
            last_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
            last_q   <= last_d;
        end
    end

    assign req_ready   = grant;
    assign res_valid   = (state_q == StDone);
    assign res_id      = id_q;
    assign res_product = acc_q;
    assign busy        = (state_q != StIdle);

endmodule
